v_hier_chanbank: RTL

Parametrised successor to the fixed 4-bit hierarchical sub-block. It holds NCHAN independent input lanes, each WIDTH bits wide. Each lane is buffered in a DEPTH-entry FIFO built from a generate loop of lane sub-modules. The lanes are merged onto one registered output stream by a round-robin arbiter with valid/ready handshake. The block sits between per-channel producers and a single shared consumer in the hierarchy test design.

---
 rtl/v_hier_pkg.sv | 18 +
 rtl/v_hier_lane_fifo.sv | 66 ++++++
 rtl/v_hier_chanbank.sv | 97 +++++++++
 3 files changed

// File: rtl/v_hier_pkg.sv
// rtl/v_hier_pkg.sv - shared widths and defaults for the channel bank
package v_hier_pkg;

  localparam int V_HIER_NCHAN = 4;
  localparam int V_HIER_WIDTH = 8;
  localparam int V_HIER_DEPTH = 4;

  // Lane index width; a single lane still needs one bit for out_chan
  function automatic int chan_w(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

  // Occupancy count width; one extra bit so that a full FIFO reads DEPTH
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/v_hier_lane_fifo.sv
// rtl/v_hier_lane_fifo.sv - per-lane registered FIFO with occupancy count
module v_hier_lane_fifo
  import v_hier_pkg::*;
#(
  parameter int WIDTH = V_HIER_WIDTH,
  parameter int DEPTH = V_HIER_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only, so a full lane never
  // accepts a word even when it is being popped in the same cycle.
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count;
  assign rdata   = mem[rd_ptr];

  // Storage array needs no reset; stale entries are never visible past count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/v_hier_chanbank.sv
// rtl/v_hier_chanbank.sv - NCHAN buffered lanes merged round-robin onto one registered stream
module v_hier_chanbank
  import v_hier_pkg::*;
#(
  parameter int NCHAN = V_HIER_NCHAN,
  parameter int WIDTH = V_HIER_WIDTH,
  parameter int DEPTH = V_HIER_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NCHAN-1:0]                in_valid,
  output logic [NCHAN-1:0]                in_ready,
  input  logic [NCHAN*WIDTH-1:0]          in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [chan_w(NCHAN)-1:0]        out_chan,
  output logic [NCHAN*lvl_w(DEPTH)-1:0]   lane_level
);

  localparam int CW = chan_w(NCHAN);
  localparam int LW = lvl_w(DEPTH);

  logic [NCHAN-1:0] lane_push;
  logic [NCHAN-1:0] lane_pop;
  logic [NCHAN-1:0] lane_full;
  logic [NCHAN-1:0] lane_empty;
  logic [WIDTH-1:0] lane_rdata [NCHAN];

  logic [CW-1:0]    rr_ptr;
  logic [CW-1:0]    rr_next;
  logic [CW-1:0]    grant;
  logic [CW-1:0]    scan;
  logic             any_req;
  logic             load;

  genvar k;
  generate
    for (k = 0; k < NCHAN; k++) begin : lanes
      v_hier_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lane_push[k]),
        .wdata (in_data[k*WIDTH +: WIDTH]),
        .pop   (lane_pop[k]),
        .rdata (lane_rdata[k]),
        .level (lane_level[k*LW +: LW]),
        .full  (lane_full[k]),
        .empty (lane_empty[k])
      );

      assign in_ready[k]  = !rst && !lane_full[k];
      assign lane_push[k] = in_valid[k] && in_ready[k];
      assign lane_pop[k]  = load && (grant == CW'(k));
    end
  endgenerate

  // Round-robin pick: scan from rr_ptr upward, the nearest non-empty lane wins.
  // Walking the offsets downward lets the smallest offset overwrite the rest.
  always_comb begin
    grant   = rr_ptr;
    any_req = 1'b0;
    scan    = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      scan = CW'((int'(rr_ptr) + i) % NCHAN);
      if (!lane_empty[scan]) begin
        grant   = scan;
        any_req = 1'b1;
      end
    end
  end

  // rr_ptr holds the lane with highest priority next time, i.e. last grant + 1
  assign rr_next = CW'((int'(grant) + 1) % NCHAN);
  assign load    = (!out_valid || out_ready) && any_req;

  // Output register: load and pop together, hold while stalled, drop when drained
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= lane_rdata[grant];
      out_chan  <= grant;
      rr_ptr    <= rr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
